// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - pipeline and data-memory signal bundle for mem_access_unit
//
// Purpose: groups the EX/MEM inputs, the MEM/WB load result, the pipeline stall
//          and the word-wide data-memory handshake into one bundle.
// Optional feature macro: MISALIGN_TRAP_EN (adds MISALIGNED).
// Signals:
//   IN_ADDRESS[ADDR_WIDTH]    byte address from EX/MEM
//   IN_WRITE_DATA[32]         store data from EX/MEM
//   IN_READ_WRITE[4]          memory op code from EX/MEM
//   BUSYWAIT                  stall request to PC and pipeline registers
//   OUT_LOAD_DATA[32]         extended load result
//   MEM_READ / MEM_WRITE      memory requests
//   MEM_ADDRESS[ADDR_WIDTH-2] word address
//   MEM_WRITEDATA[32]         lane-positioned store data
//   MEM_BYTE_EN[4]            write byte lanes
//   MEM_READDATA[32]          memory read word
//   MEM_BUSYWAIT              memory busy
//   MISALIGNED                misaligned-access flag (MISALIGN_TRAP_EN only)
// Modports: slave = the load/store unit, master = its environment.

interface mem_access_unit_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] IN_ADDRESS;
   logic [31:0]           IN_WRITE_DATA;
   logic [3:0]            IN_READ_WRITE;
   logic                  BUSYWAIT;
   logic [31:0]           OUT_LOAD_DATA;
   logic                  MEM_READ;
   logic                  MEM_WRITE;
   logic [ADDR_WIDTH-3:0] MEM_ADDRESS;
   logic [31:0]           MEM_WRITEDATA;
   logic [3:0]            MEM_BYTE_EN;
   logic [31:0]           MEM_READDATA;
   logic                  MEM_BUSYWAIT;
`ifdef MISALIGN_TRAP_EN
   logic                  MISALIGNED;
`endif

   modport slave (
      input  IN_ADDRESS,
      input  IN_WRITE_DATA,
      input  IN_READ_WRITE,
      input  MEM_READDATA,
      input  MEM_BUSYWAIT,
      output BUSYWAIT,
      output OUT_LOAD_DATA,
      output MEM_READ,
      output MEM_WRITE,
      output MEM_ADDRESS,
      output MEM_WRITEDATA,
      output MEM_BYTE_EN
`ifdef MISALIGN_TRAP_EN
      ,
      output MISALIGNED
`endif
   );

   modport master (
      output IN_ADDRESS,
      output IN_WRITE_DATA,
      output IN_READ_WRITE,
      output MEM_READDATA,
      output MEM_BUSYWAIT,
      input  BUSYWAIT,
      input  OUT_LOAD_DATA,
      input  MEM_READ,
      input  MEM_WRITE,
      input  MEM_ADDRESS,
      input  MEM_WRITEDATA,
      input  MEM_BYTE_EN
`ifdef MISALIGN_TRAP_EN
      ,
      input  MISALIGNED
`endif
   );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit for the RV32IM MEM stage
//
// Purpose: performs one byte/halfword/word access per EX/MEM op against a
//          word-wide data memory with a variable-latency handshake, stalls the
//          pipeline via BUSYWAIT for the whole access, and returns a sign- or
//          zero-extended load result.
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses issue no memory request, take a
//               single stall cycle and raise MISALIGNED during DONE.
//   undefined : offending low address bits are ignored.
// Ports:
//   CLK    pipeline clock, rising edge
//   RESET  synchronous, active-high
//   bus    mem_access_unit_if.slave (EX/MEM inputs, stall, load result,
//          data-memory request/response)

module mem_access_unit #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                CLK,
   input  logic                RESET,
   mem_access_unit_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   state_t r_state;
   state_t w_next_state;

   logic                  r_mem_read;
   logic                  r_mem_write;
   logic [ADDR_WIDTH-3:0] r_mem_address;
   logic [31:0]           r_mem_writedata;
   logic [3:0]            r_mem_byte_en;
   logic [31:0]           r_load_data;
   logic [2:0]            r_ld_f3;
   logic [1:0]            r_off;

   logic [2:0]  w_f3;
   logic        w_is_load;
   logic        w_is_store;
   logic        w_valid;
   logic [1:0]  w_size;
   logic        w_issue;
   logic [3:0]  w_byte_en;
   logic [31:0] w_wdata;
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic [31:0] w_load_ext;
   logic        w_busywait;

`ifdef MISALIGN_TRAP_EN
   logic        r_misaligned;
   logic        w_misaligned;
   logic        w_trap;
`endif

   assign w_f3 = bus.IN_READ_WRITE[2:0];

   // Op decode; any code outside the legal load/store set is idle.
   always_comb begin
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      w_size     = SZ_BYTE;
      if (bus.IN_READ_WRITE[3]) begin
         case (w_f3)
            3'b000, 3'b100: begin w_is_load = 1'b1; w_size = SZ_BYTE; end
            3'b001, 3'b101: begin w_is_load = 1'b1; w_size = SZ_HALF; end
            3'b010:         begin w_is_load = 1'b1; w_size = SZ_WORD; end
            default: ;
         endcase
      end else begin
         case (w_f3)
            3'b001: begin w_is_store = 1'b1; w_size = SZ_BYTE; end
            3'b010: begin w_is_store = 1'b1; w_size = SZ_HALF; end
            3'b011: begin w_is_store = 1'b1; w_size = SZ_WORD; end
            default: ;
         endcase
      end
   end

   assign w_valid = w_is_load | w_is_store;

`ifdef MISALIGN_TRAP_EN
   assign w_misaligned = ((w_size == SZ_HALF) && bus.IN_ADDRESS[0]) ||
                         ((w_size == SZ_WORD) && (bus.IN_ADDRESS[1:0] != 2'b00));
   assign w_trap  = w_valid & w_misaligned;
   assign w_issue = w_valid & ~w_misaligned;
`else
   assign w_issue = w_valid;
`endif

   // Store lane steering: data is replicated across lanes so the byte
   // enables alone pick the destination bytes.
   always_comb begin
      w_byte_en = 4'b0000;
      w_wdata   = 32'h0;
      if (w_is_store) begin
         case (w_size)
            SZ_BYTE: begin
               w_byte_en = 4'b0001 << bus.IN_ADDRESS[1:0];
               w_wdata   = {4{bus.IN_WRITE_DATA[7:0]}};
            end
            SZ_HALF: begin
               w_byte_en = bus.IN_ADDRESS[1] ? 4'b1100 : 4'b0011;
               w_wdata   = {2{bus.IN_WRITE_DATA[15:0]}};
            end
            default: begin
               w_byte_en = 4'b1111;
               w_wdata   = bus.IN_WRITE_DATA;
            end
         endcase
      end
   end

   // Load extraction uses the offset and funct3 captured at issue.
   always_comb begin
      w_ld_byte  = 8'h0;
      w_ld_half  = 16'h0;
      w_load_ext = 32'h0;
      case (r_off)
         2'd0:    w_ld_byte = bus.MEM_READDATA[7:0];
         2'd1:    w_ld_byte = bus.MEM_READDATA[15:8];
         2'd2:    w_ld_byte = bus.MEM_READDATA[23:16];
         default: w_ld_byte = bus.MEM_READDATA[31:24];
      endcase
      w_ld_half = r_off[1] ? bus.MEM_READDATA[31:16] : bus.MEM_READDATA[15:0];
      case (r_ld_f3[1:0])
         2'b00:   w_load_ext = r_ld_f3[2] ? {24'h0, w_ld_byte}
                                          : {{24{w_ld_byte[7]}}, w_ld_byte};
         2'b01:   w_load_ext = r_ld_f3[2] ? {16'h0, w_ld_half}
                                          : {{16{w_ld_half[15]}}, w_ld_half};
         default: w_load_ext = bus.MEM_READDATA;
      endcase
   end

   // FSM: state register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM: next state. DONE always returns to IDLE so identical back-to-back
   // ops are still seen as new accesses.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
`ifdef MISALIGN_TRAP_EN
            if (w_trap) begin
               w_next_state = S_DONE;
            end else if (w_issue) begin
               w_next_state = S_ACCESS;
            end
`else
            if (w_issue) begin
               w_next_state = S_ACCESS;
            end
`endif
         end
         S_ACCESS: begin
            if (!bus.MEM_BUSYWAIT) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // FSM: outputs. The stall is raised combinationally in IDLE so the
   // pipeline holds from the very cycle the op appears; DONE releases it.
   always_comb begin
      w_busywait = 1'b0;
      if (!RESET) begin
         case (r_state)
            S_IDLE:   w_busywait = w_valid;
            S_ACCESS: w_busywait = 1'b1;
            default:  w_busywait = 1'b0;
         endcase
      end
   end

   // Memory-side registers and the load result.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_mem_read      <= 1'b0;
         r_mem_write     <= 1'b0;
         r_mem_address   <= '0;
         r_mem_writedata <= 32'h0;
         r_mem_byte_en   <= 4'b0000;
         r_load_data     <= 32'h0;
         r_ld_f3         <= 3'b000;
         r_off           <= 2'b00;
`ifdef MISALIGN_TRAP_EN
         r_misaligned    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_mem_read      <= w_is_load;
                  r_mem_write     <= w_is_store;
                  r_mem_address   <= bus.IN_ADDRESS[ADDR_WIDTH-1:2];
                  r_mem_writedata <= w_wdata;
                  r_mem_byte_en   <= w_byte_en;
                  r_ld_f3         <= w_f3;
                  r_off           <= bus.IN_ADDRESS[1:0];
               end
`ifdef MISALIGN_TRAP_EN
               if (w_trap) begin
                  r_misaligned <= 1'b1;
                  if (w_is_load) begin
                     r_load_data <= 32'h0;
                  end
               end
`endif
            end
            S_ACCESS: begin
               if (!bus.MEM_BUSYWAIT) begin
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  if (r_mem_read) begin
                     r_load_data <= w_load_ext;
                  end
               end
            end
            S_DONE: begin
`ifdef MISALIGN_TRAP_EN
               r_misaligned <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.BUSYWAIT      = w_busywait;
   assign bus.OUT_LOAD_DATA = r_load_data;
   assign bus.MEM_READ      = r_mem_read;
   assign bus.MEM_WRITE     = r_mem_write;
   assign bus.MEM_ADDRESS   = r_mem_address;
   assign bus.MEM_WRITEDATA = r_mem_writedata;
   assign bus.MEM_BYTE_EN   = r_mem_byte_en;
`ifdef MISALIGN_TRAP_EN
   assign bus.MISALIGNED    = r_misaligned;
`endif

endmodule
